// File: rtl/metro_mpi_pkg.sv
// Shared MPI/NoC types and header-field constants for the MPI bridge blocks.
package metro_mpi_pkg;

  localparam int unsigned NOC_FLIT_W  = 64;
  localparam int unsigned NOC_LEN_LSB = 22;
  localparam int unsigned NOC_LEN_W   = 8;

  typedef logic [NOC_FLIT_W-1:0] flit_t;

  // Output-side packet framing state
  typedef enum logic {
    RX_HEAD = 1'b0,
    RX_BODY = 1'b1
  } rx_frame_e;

endpackage

// File: rtl/mpi_flit_fifo.sv
// DEPTH-entry flit FIFO: storage, wrap-around pointers and occupancy count.
module mpi_flit_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  // Storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (pop_i) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/mpi_noc_rx_buffer.sv
// Receive-side NoC flit buffer with yummy credit return and packet framing.
// Optional MPI_RX_TRACE_EN adds push/pop/overflow trace output.
module mpi_noc_rx_buffer
  import metro_mpi_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = $bits(flit_t),
  parameter int unsigned LEN_LSB = NOC_LEN_LSB,
  parameter int unsigned LEN_W   = NOC_LEN_W
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  int                      rank_i,
  input  logic                    valid_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    yummy_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    sop_o,
  output logic                    eop_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [LEN_W-1:0] w_len;

  rx_frame_e        r_state;
  rx_frame_e        w_state_next;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_next;
  logic             r_yummy;
  logic             r_overflow;

  // A full FIFO still accepts a flit when the head leaves in the same cycle
  assign w_pop  = valid_o && ready_i;
  assign w_push = valid_i && (!w_full || w_pop);
  assign w_drop = valid_i && w_full && !w_pop;

  mpi_flit_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (data_i),
    .data_o  (data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  assign valid_o = !w_empty;
  assign w_len   = data_o[LEN_LSB +: LEN_W];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= RX_HEAD;
      r_rem      <= '0;
      r_yummy    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_yummy    <= w_pop;
      r_overflow <= r_overflow || w_drop;
    end
  end

  // Framing advances only when the consumer takes the head flit
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    sop_o        = 1'b0;
    eop_o        = 1'b0;
    case (r_state)
      RX_HEAD: begin
        sop_o = valid_o;
        eop_o = valid_o && (w_len == '0);
        if (w_pop && (w_len != '0)) begin
          w_rem_next   = w_len;
          w_state_next = RX_BODY;
        end
      end
      RX_BODY: begin
        eop_o = valid_o && (r_rem == LEN_W'(1));
        if (w_pop) begin
          w_rem_next = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_next = RX_HEAD;
          end
        end
      end
      default: begin
        w_state_next = RX_HEAD;
        w_rem_next   = '0;
      end
    endcase
  end

  assign yummy_o    = r_yummy;
  assign overflow_o = r_overflow;

`ifdef MPI_RX_TRACE_EN
  logic [$clog2(DEPTH):0] w_occ_next;

  always_comb begin
    w_occ_next = count_o;
    if (w_push && !w_pop) begin
      w_occ_next = count_o + ($clog2(DEPTH)+1)'(1);
    end else if (w_pop && !w_push) begin
      w_occ_next = count_o - ($clog2(DEPTH)+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      if (w_push) begin
        $display("[mpi_rx rank %0d] push flit=%h occ=%0d sop=%b eop=%b",
                 rank_i, data_i, w_occ_next, sop_o, eop_o);
      end
      if (w_pop) begin
        $display("[mpi_rx rank %0d] pop  flit=%h occ=%0d sop=%b eop=%b",
                 rank_i, data_o, w_occ_next, sop_o, eop_o);
      end
      if (w_drop) begin
        $display("[mpi_rx rank %0d] overflow dropped flit=%h", rank_i, data_i);
      end
    end
  end
`else
  logic w_unused_rank;
  assign w_unused_rank = ^rank_i;
`endif

endmodule

// File: tb/tb_mpi_noc_rx_buffer.sv
// Self-checking bench for mpi_noc_rx_buffer against a queue-based packet model.
module tb_mpi_noc_rx_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LEN_LSB = 22;
  localparam int unsigned LEN_W   = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  int          rank_i;
  logic        valid_i;
  logic [63:0] data_i;
  logic        yummy_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        sop_o;
  logic        eop_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  mpi_noc_rx_buffer dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rank_i     (rank_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .yummy_o    (yummy_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sop_o      (sop_o),
    .eop_o      (eop_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: FIFO contents, flits still owed by the current packet (0 = next is a header),
  // last-cycle pop for the credit, and the sticky overflow flag.
  logic [63:0] m_q[$];
  int          m_pkt_left;
  bit          m_yummy;
  bit          m_ovf;

  int checks = 0;
  int errors = 0;

  function automatic int hdr_len(logic [63:0] f);
    return int'(f[LEN_LSB +: LEN_W]);
  endfunction

  function automatic logic [63:0] mk_flit(int len);
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[LEN_LSB +: LEN_W] = LEN_W'(len);
    return f;
  endfunction

  function automatic logic [7:0] m_status();
    logic v, s, e;
    v = (m_q.size() != 0);
    s = 1'b0;
    e = 1'b0;
    if (v) begin
      s = (m_pkt_left == 0);
      e = (m_pkt_left == 0) ? (hdr_len(m_q[0]) == 0) : (m_pkt_left == 1);
    end
    return {v, s, e, m_yummy, m_ovf, 3'(m_q.size())};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pkt_left = 0;
    m_yummy    = 1'b0;
    m_ovf      = 1'b0;
  endfunction

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    @(negedge clk_i);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
  endtask

  // Apply the current inputs to the model, then let the clock edge happen
  task automatic advance();
    bit full, pop, push;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && (ready_i === 1'b1);
    push = (valid_i === 1'b1) && (!full || pop);
    if ((valid_i === 1'b1) && full && !pop) m_ovf = 1'b1;
    m_yummy = pop;
    if (pop) begin
      if (m_pkt_left == 0) m_pkt_left = hdr_len(m_q[0]);
      else m_pkt_left--;
      void'(m_q.pop_front());
    end
    if (push) m_q.push_back(data_i);
    @(posedge clk_i);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    rstn_i  = 1'b0;
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    rank_i  = 7;
    rstn_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold status got=%b want=%b",
               {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, 8'h00);
    end
    rstn_i = 1'b1;
    drive(1'b0, '0, 1'b1);
    checks++;
    if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_release status got=%b want=%b",
               {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, 8'h00);
    end
    advance();
  endtask

  task automatic test_single_flit_headers();
    int ycnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive(1'b1, mk_flit(0), 1'b0);
      else       drive(1'b0, '0, (i < 8));
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL single_hdr cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (data_o !== m_q[0]) begin
          errors++;
          $display("FAIL single_hdr cyc=%0d data got=%h want=%h", i, data_o, m_q[0]);
        end
      end
      if (i == 4) begin
        checks++;
        if (count_o !== 3'd4) begin
          errors++;
          $display("FAIL single_hdr_full count got=%0d want=4", count_o);
        end
      end
      if (yummy_o === 1'b1) ycnt++;
      advance();
    end
    checks++;
    if (ycnt != 4) begin
      errors++;
      $display("FAIL single_hdr_yummy_total got=%0d want=4", ycnt);
    end
  endtask

  task automatic test_multi_flit();
    logic [63:0] pkt[4];
    pkt[0] = mk_flit(2);
    pkt[1] = mk_flit($urandom_range(0, 255));
    pkt[2] = mk_flit($urandom_range(0, 255));
    pkt[3] = mk_flit(0);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, pkt[i], 1'b1);
      else       drive(1'b0, '0, 1'b1);
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL multi_flit cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (data_o !== m_q[0]) begin
          errors++;
          $display("FAIL multi_flit cyc=%0d data got=%h want=%h", i, data_o, m_q[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    logic [63:0] dropped;
    dropped = mk_flit(0);
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       drive(1'b1, mk_flit(0), 1'b0);
      else if (i == 4) drive(1'b1, dropped, 1'b0);
      else             drive(1'b0, '0, (i >= 7));
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL overflow cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (data_o !== m_q[0]) begin
          errors++;
          $display("FAIL overflow cyc=%0d data got=%h want=%h", i, data_o, m_q[0]);
        end
      end
      advance();
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b want=1", overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 4)       drive(1'b1, mk_flit(0), 1'b0);
      else if (i == 4) drive(1'b1, mk_flit(0), 1'b1);
      else             drive(1'b0, '0, (i >= 7));
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL full_push_pop cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (data_o !== m_q[0]) begin
          errors++;
          $display("FAIL full_push_pop cyc=%0d data got=%h want=%h", i, data_o, m_q[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if ({yummy_o, overflow_o, count_o} !== 5'b10100) begin
          errors++;
          $display("FAIL full_push_pop_after yummy/ovf/count got=%b want=10100",
                   {yummy_o, overflow_o, count_o});
        end
      end
      advance();
    end
  endtask

  task automatic test_wraparound();
    logic [63:0] sent[$];
    logic [63:0] got[$];
    int idx = 0, ycnt = 0, maxo = 0, cyc = 0;
    bit r = 1'b1;
    bit v;
    apply_reset();
    while (sent.size() < 20) begin
      int room = 20 - sent.size();
      int l = $urandom_range(0, 3);
      if (l > room - 1) l = room - 1;
      sent.push_back(mk_flit(l));
      for (int k = 0; k < l; k++) sent.push_back(mk_flit($urandom_range(0, 255)));
    end
    while (got.size() < 20 && cyc < 200) begin
      v = (idx < 20) && (m_q.size() < DEPTH || r);
      if (v) drive(1'b1, sent[idx], r);
      else   drive(1'b0, '0, r);
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL wrap cyc=%0d status got=%b want=%b", cyc,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (yummy_o === 1'b1) ycnt++;
      if (int'(count_o) > maxo) maxo = int'(count_o);
      if (valid_o === 1'b1 && ready_i === 1'b1) got.push_back(data_o);
      if (v) idx++;
      advance();
      r = !r;
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    if (yummy_o === 1'b1) ycnt++;
    advance();
    checks++;
    if (got.size() != 20) begin
      errors++;
      $display("FAIL wrap_drained got=%0d flits want=20 (cycle budget)", got.size());
    end
    for (int k = 0; k < 20 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== sent[k]) begin
        errors++;
        $display("FAIL wrap_order idx=%0d got=%h want=%h", k, got[k], sent[k]);
      end
    end
    checks++;
    if (ycnt != 20) begin
      errors++;
      $display("FAIL wrap_yummy_total got=%0d want=20", ycnt);
    end
    checks++;
    if (maxo > DEPTH) begin
      errors++;
      $display("FAIL wrap_max_occ got=%0d want<=%0d", maxo, DEPTH);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      drive(1'b1, mk_flit(3), 1'b0);
      else if (i == 1) drive(1'b1, mk_flit(9), 1'b1);
      else             drive(1'b1, mk_flit(1), 1'b0);
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL mid_pkt cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      advance();
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1 rstn_i = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({valid_o, yummy_o, count_o} !== 5'b0) begin
      errors++;
      $display("FAIL mid_pkt_async_reset valid/yummy/count got=%b want=00000",
               {valid_o, yummy_o, count_o});
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b1, mk_flit(5), 1'b0);
      else        drive(1'b0, '0, 1'b0);
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL mid_pkt_after cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (i == 1) begin
        checks++;
        if (sop_o !== 1'b1) begin
          errors++;
          $display("FAIL mid_pkt_new_header sop got=%b want=1", sop_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), mk_flit($urandom_range(0, 3)),
            1'($urandom_range(0, 99) < 45));
      checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o} !== m_status()) begin
        errors++;
        $display("FAIL random cyc=%0d status got=%b want=%b", i,
                 {valid_o, sop_o, eop_o, yummy_o, overflow_o, count_o}, m_status());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (data_o !== m_q[0]) begin
          errors++;
          $display("FAIL random cyc=%0d data got=%h want=%h", i, data_o, m_q[0]);
        end
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_flit_headers();
    test_multi_flit();
    test_overflow();
    test_full_push_pop();
    test_wraparound();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
